// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger playfield blocks.
//   - FSM state typedef used by lane_scheduler
//   - RRRGGGBB color constants for the pixel mux
//   - playfield geometry: 20 x 10 cells of 32 x 48 pixels (640 x 480)
//   - step_col(): one-column move with wrap at the playfield edges
package frogger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

  localparam logic [7:0] COLOR_FROG  = 8'b00011100;
  localparam logic [7:0] COLOR_OBST  = 8'b11100000;
  localparam logic [7:0] COLOR_LANE  = 8'b01001001;
  localparam logic [7:0] COLOR_BLACK = 8'h00;

  localparam int CELL_W    = 32;
  localparam int ROW_H     = 48;
  localparam int GRID_COLS = 20;
  localparam int GRID_ROWS = 10;

  // dir = 0 moves right (19 wraps to 0), dir = 1 moves left (0 wraps to 19)
  function automatic logic [4:0] step_col(input logic [4:0] col, input logic dir);
    logic [4:0] r;
    if (!dir) r = (col == 5'(GRID_COLS - 1)) ? 5'd0 : col + 5'd1;
    else      r = (col == 5'd0) ? 5'(GRID_COLS - 1) : col - 5'd1;
    return r;
  endfunction

endpackage

// File: rtl/lane_stepper.sv
// One obstacle lane: an 8-bit frame counter and the lane's column.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   step_en      : one-cycle qualifier (a frame strobe while running)
//   period       : frames per column step
//   dir          : 0 = move right, 1 = move left
//   col          : current obstacle column (reset value INIT_COL)
module lane_stepper
  import frogger_pkg::*;
#(
  parameter logic [4:0] INIT_COL = 5'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step_en,
  input  logic [7:0] period,
  input  logic       dir,
  output logic [4:0] col
);

  logic [7:0] frame_cnt;

  // The counter wraps to 0 on the strobe that completes a period, and the
  // column moves on that same cycle, so a lane steps once every 'period'
  // strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= 8'd0;
      col       <= INIT_COL;
    end else if (step_en) begin
      if (frame_cnt + 8'd1 == period) begin
        frame_cnt <= 8'd0;
        col       <= step_col(col, dir);
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/lane_scheduler.sv
// Obstacle lane scheduler with collision FSM and pixel color mux.
// Build option: define LANE_SCHEDULER_COLLISION_EN to enable collision
// detection and the HIT state; otherwise HIT is unreachable, collision is 0
// and clear is ignored.
// Ports:
//   clock, reset         : 25 MHz pixel clock, synchronous active-high reset
//   frame_strobe         : one-cycle pulse per frame; lanes advance on it in RUN
//   run_en               : level, IDLE->RUN while high, RUN->IDLE when low
//   clear                : one-cycle pulse, HIT->IDLE
//   next_x, next_y       : coordinates of the next pixel to be shown
//   frog_row, frog_col   : frog cell
//   color_out            : RRRGGGBB, registered, 1 clock after next_x/next_y
//   collision            : high while in HIT
//   state_out            : current FSM state (IDLE=0, RUN=1, HIT=2)
// There is no valid/ready handshake here: frame_strobe and clear are
// single-cycle pulses that are acted on in the cycle they are high.
module lane_scheduler
  import frogger_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int STEP_PERIOD    = 8,
  parameter int FIRST_LANE_ROW = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_strobe,
  input  logic       run_en,
  input  logic       clear,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  input  logic [3:0] frog_row,
  input  logic [4:0] frog_col,
  output logic [7:0] color_out,
  output logic       collision,
  output logic [1:0] state_out
);

  state_t     state, state_nxt;
  logic [4:0] lane_col [NUM_LANES];
  logic       lane_step;
  logic       hit_now;

  assign lane_step = frame_strobe && (state == ST_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lane_stepper #(
        .INIT_COL(5'((gi * 5) % GRID_COLS))
      ) u_stepper (
        .clock  (clock),
        .reset  (reset),
        .step_en(lane_step),
        .period (8'(STEP_PERIOD * (gi + 1))),
        .dir    (gi[0]),
        .col    (lane_col[gi])
      );
    end
  endgenerate

  // Collision uses the columns registered before this strobe's step.
`ifdef LANE_SCHEDULER_COLLISION_EN
  always_comb begin
    hit_now = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (frog_row == 4'(FIRST_LANE_ROW + i) && frog_col == lane_col[i])
        hit_now = 1'b1;
    end
    hit_now = hit_now && lane_step;
  end
`else
  logic unused_clear;
  assign hit_now      = 1'b0;
  assign unused_clear = clear;
`endif

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (run_en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!run_en)     state_nxt = ST_IDLE;
        else if (hit_now) state_nxt = ST_HIT;
      end
`ifdef LANE_SCHEDULER_COLLISION_EN
      ST_HIT:  if (clear) state_nxt = ST_IDLE;
`endif
      default: state_nxt = state;
    endcase
  end

  // FSM: outputs
  always_comb begin
    collision = (state == ST_HIT);
    state_out = state;
  end

  // Pixel color mux. Row comes from threshold compares against multiples
  // of ROW_H so no divider is needed; column is a plain shift by CELL_W.
  logic [3:0] pix_row;
  logic [4:0] pix_col;
  logic       on_obst, on_frog, in_lane;
  logic [7:0] pix_color;

  always_comb begin
    pix_row = 4'd0;
    for (int k = 1; k < GRID_ROWS; k++) begin
      if (next_y >= 10'(k * ROW_H)) pix_row = 4'(k);
    end
    pix_col = next_x[9:5];
    in_lane = (int'(pix_row) >= FIRST_LANE_ROW) &&
              (int'(pix_row) < FIRST_LANE_ROW + NUM_LANES);
    on_obst = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (pix_row == 4'(FIRST_LANE_ROW + i) && pix_col == lane_col[i])
        on_obst = 1'b1;
    end
    on_frog = (pix_row == frog_row) && (pix_col == frog_col);
    if (next_x >= 10'(GRID_COLS * CELL_W) || next_y >= 10'(GRID_ROWS * ROW_H))
      pix_color = COLOR_BLACK;
    else if (on_frog) pix_color = COLOR_FROG;
    else if (on_obst) pix_color = COLOR_OBST;
    else if (in_lane) pix_color = COLOR_LANE;
    else              pix_color = COLOR_BLACK;
  end

  always_ff @(posedge clock) begin
    if (reset) color_out <= COLOR_BLACK;
    else       color_out <= pix_color;
  end

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed bench for lane_scheduler with default parameters
// (4 lanes, STEP_PERIOD 8, first lane row 3). Inputs change and outputs
// are sampled on the falling clock edge.
module tb_lane_scheduler;

  localparam logic [7:0] RED   = 8'b11100000;
  localparam logic [7:0] GREEN = 8'b00011100;
  localparam logic [7:0] LANE  = 8'b01001001;
  localparam logic [7:0] BLACK = 8'h00;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_strobe = 1'b0;
  logic       run_en = 1'b0;
  logic       clear = 1'b0;
  logic [9:0] next_x = 10'd700;
  logic [9:0] next_y = 10'd0;
  logic [3:0] frog_row = 4'd9;
  logic [4:0] frog_col = 5'd19;
  logic [7:0] color_out;
  logic       collision;
  logic [1:0] state_out;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #20 clock = ~clock;

  lane_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .frame_strobe(frame_strobe),
    .run_en      (run_en),
    .clear       (clear),
    .next_x      (next_x),
    .next_y      (next_y),
    .frog_row    (frog_row),
    .frog_col    (frog_col),
    .color_out   (color_out),
    .collision   (collision),
    .state_out   (state_out)
  );

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    run_en = 1'b0;
    frame_strobe = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic strobe(input int n);
    for (int s = 0; s < n; s++) begin
      @(negedge clock);
      frame_strobe = 1'b1;
      @(negedge clock);
      frame_strobe = 1'b0;
    end
  endtask

  task automatic go_run();
    @(negedge clock);
    run_en = 1'b1;
    @(negedge clock);
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  // Returns the color registered for the centre-ish pixel of a cell.
  task automatic probe(input int row, input int col, output logic [7:0] c);
    @(negedge clock);
    next_x = 10'(col * 32 + 5);
    next_y = 10'(row * 48 + 5);
    @(negedge clock);
    c = color_out;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] c;
    int exp_col [4] = '{0, 5, 10, 15};
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_out); end
    checks++;
    if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision got=%b exp=0", collision); end
    checks++;
    if (color_out !== BLACK) begin errors++; $display("FAIL reset_color got=%h exp=%h", color_out, BLACK); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      probe(3 + i, exp_col[i], c);
      checks++;
      if (c !== RED) begin errors++; $display("FAIL reset_lane%0d_col%0d got=%h exp=%h", i, exp_col[i], c, RED); end
    end
    probe(3, 1, c);
    checks++;
    if (c !== LANE) begin errors++; $display("FAIL reset_lane0_bg got=%h exp=%h", c, LANE); end
  endtask

  task automatic test_pixel();
    logic [7:0] c;
    apply_reset();
    @(negedge clock);
    next_x = 10'd700; next_y = 10'd0;
    @(negedge clock);
    checks++;
    if (color_out !== BLACK) begin errors++; $display("FAIL x700 got=%h exp=%h", color_out, BLACK); end
    // obstacle pixel appears one clock later, not in the same cycle
    next_x = 10'd10; next_y = 10'd160;
    #1;
    checks++;
    if (color_out !== BLACK) begin errors++; $display("FAIL latency_early got=%h exp=%h", color_out, BLACK); end
    @(negedge clock);
    checks++;
    if (color_out !== RED) begin errors++; $display("FAIL obst_10_160 got=%h exp=%h", color_out, RED); end
    next_x = 10'd100; next_y = 10'd500;
    @(negedge clock);
    checks++;
    if (color_out !== BLACK) begin errors++; $display("FAIL y500 got=%h exp=%h", color_out, BLACK); end
    probe(4, 0, c);
    checks++;
    if (c !== LANE) begin errors++; $display("FAIL lane_bg got=%h exp=%h", c, LANE); end
    probe(0, 3, c);
    checks++;
    if (c !== BLACK) begin errors++; $display("FAIL non_lane_row got=%h exp=%h", c, BLACK); end
    // last visible pixel sits in the frog cell (9,19)
    @(negedge clock);
    next_x = 10'd639; next_y = 10'd479;
    @(negedge clock);
    checks++;
    if (color_out !== GREEN) begin errors++; $display("FAIL frog_639_479 got=%h exp=%h", color_out, GREEN); end
    // row 3 starts at y=144; y=143 is still row 2
    @(negedge clock);
    next_x = 10'd10; next_y = 10'd143;
    @(negedge clock);
    checks++;
    if (color_out !== BLACK) begin errors++; $display("FAIL y143 got=%h exp=%h", color_out, BLACK); end
    // frog on top of obstacle wins
    frog_row = 4'd3; frog_col = 5'd0;
    probe(3, 0, c);
    checks++;
    if (c !== GREEN) begin errors++; $display("FAIL frog_over_obst got=%h exp=%h", c, GREEN); end
    frog_row = 4'd9; frog_col = 5'd19;
  endtask

  task automatic test_step();
    logic [7:0] c;
    apply_reset();
    go_run();
    checks++;
    if (state_out !== 2'd1) begin errors++; $display("FAIL run_state got=%0d exp=1", state_out); end
    strobe(8);
    probe(3, 1, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s8_lane0_col1 got=%h exp=%h", c, RED); end
    probe(4, 5, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s8_lane1_col5 got=%h exp=%h", c, RED); end
    probe(5, 10, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s8_lane2_col10 got=%h exp=%h", c, RED); end
    strobe(8);
    probe(3, 2, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s16_lane0_col2 got=%h exp=%h", c, RED); end
    probe(4, 4, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s16_lane1_col4 got=%h exp=%h", c, RED); end
    @(negedge clock);
    run_en = 1'b0;
    @(negedge clock);
    checks++;
    if (state_out !== 2'd0) begin errors++; $display("FAIL idle_state got=%0d exp=0", state_out); end
    strobe(8);
    probe(3, 2, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL idle_hold_lane0 got=%h exp=%h", c, RED); end
  endtask

  task automatic test_wrap();
    logic [7:0] c;
    apply_reset();
    go_run();
    strobe(80);
    probe(4, 0, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s80_lane1_col0 got=%h exp=%h", c, RED); end
    strobe(16);
    probe(4, 19, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s96_lane1_col19 got=%h exp=%h", c, RED); end
    probe(3, 12, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s96_lane0_col12 got=%h exp=%h", c, RED); end
    strobe(56);
    probe(3, 19, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s152_lane0_col19 got=%h exp=%h", c, RED); end
    strobe(8);
    probe(3, 0, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s160_lane0_col0 got=%h exp=%h", c, RED); end
    probe(4, 15, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s160_lane1_col15 got=%h exp=%h", c, RED); end
    probe(5, 16, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s160_lane2_col16 got=%h exp=%h", c, RED); end
    probe(6, 10, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL s160_lane3_col10 got=%h exp=%h", c, RED); end
  endtask

  task automatic test_collision();
    logic [7:0] c;
    apply_reset();
    go_run();
    frog_row = 4'd3; frog_col = 5'd0;
    strobe(1);
`ifdef LANE_SCHEDULER_COLLISION_EN
    checks++;
    if (state_out !== 2'd2) begin errors++; $display("FAIL hit_state got=%0d exp=2", state_out); end
    checks++;
    if (collision !== 1'b1) begin errors++; $display("FAIL hit_collision got=%b exp=1", collision); end
    strobe(16);
    probe(4, 5, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL hit_frozen_lane1 got=%h exp=%h", c, RED); end
    probe(3, 1, c);
    checks++;
    if (c !== LANE) begin errors++; $display("FAIL hit_frozen_lane0 got=%h exp=%h", c, LANE); end
    pulse_clear();
    checks++;
    if (state_out !== 2'd0) begin errors++; $display("FAIL clear_state got=%0d exp=0", state_out); end
    checks++;
    if (collision !== 1'b0) begin errors++; $display("FAIL clear_collision got=%b exp=0", collision); end
`else
    checks++;
    if (state_out !== 2'd1) begin errors++; $display("FAIL nohit_state got=%0d exp=1", state_out); end
    checks++;
    if (collision !== 1'b0) begin errors++; $display("FAIL nohit_collision got=%b exp=0", collision); end
    strobe(16);
    probe(4, 4, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL nohit_lane1_col4 got=%h exp=%h", c, RED); end
    pulse_clear();
    checks++;
    if (state_out !== 2'd1) begin errors++; $display("FAIL nohit_clear_state got=%0d exp=1", state_out); end
`endif
    frog_row = 4'd9; frog_col = 5'd19;
  endtask

  task automatic test_same_strobe();
    logic [7:0] c;
    apply_reset();
    go_run();
    strobe(7);
    frog_row = 4'd3; frog_col = 5'd0;
    strobe(1);
`ifdef LANE_SCHEDULER_COLLISION_EN
    checks++;
    if (state_out !== 2'd2) begin errors++; $display("FAIL same_hit_state got=%0d exp=2", state_out); end
`else
    checks++;
    if (state_out !== 2'd1) begin errors++; $display("FAIL same_run_state got=%0d exp=1", state_out); end
`endif
    probe(3, 1, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL same_lane0_stepped got=%h exp=%h", c, RED); end
    // reset wins over a simultaneous clear
    @(negedge clock);
    reset = 1'b1; clear = 1'b1;
    @(negedge clock);
    checks++;
    if (state_out !== 2'd0) begin errors++; $display("FAIL reset_clear_state got=%0d exp=0", state_out); end
    checks++;
    if (collision !== 1'b0) begin errors++; $display("FAIL reset_clear_collision got=%b exp=0", collision); end
    reset = 1'b0; clear = 1'b0; run_en = 1'b0;
    frog_row = 4'd9; frog_col = 5'd19;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] c;
    int exp_col [4] = '{0, 5, 10, 15};
    apply_reset();
    go_run();
    strobe(20);
    @(negedge clock);
    next_x = 10'd10; next_y = 10'd160;
    reset = 1'b1; run_en = 1'b0;
    @(negedge clock);
    checks++;
    if (state_out !== 2'd0) begin errors++; $display("FAIL midrun_state got=%0d exp=0", state_out); end
    checks++;
    if (color_out !== BLACK) begin errors++; $display("FAIL midrun_color got=%h exp=%h", color_out, BLACK); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      probe(3 + i, exp_col[i], c);
      checks++;
      if (c !== RED) begin errors++; $display("FAIL midrun_lane%0d got=%h exp=%h", i, c, RED); end
    end
    go_run();
    strobe(8);
    probe(3, 1, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL midrun_cnt_lane0 got=%h exp=%h", c, RED); end
    probe(4, 5, c);
    checks++;
    if (c !== RED) begin errors++; $display("FAIL midrun_cnt_lane1 got=%h exp=%h", c, RED); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    repeat (2) @(negedge clock);
    test_reset();
    test_pixel();
    test_step();
    test_wrap();
    test_collision();
    test_same_strobe();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
